rng_prefetch: RTL and testbench

- Downstream consumer of the simplerng LFSR stage, placed between that stage and the SoC register bus.
- Seeds the RNG, discards a warm-up run, then prefetches random words into a small FIFO.
- Processor reads are served from the FIFO with no wait whenever a word is buffered.
- A processor write re-seeds the RNG and flushes the FIFO.

---
 rtl/rng_pkg.sv | 20 ++
 rtl/rng_fifo.sv | 54 +++++
 rtl/rng_prefetch.sv | 150 +++++++++++++++
 tb/tb_rng_prefetch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG prefetch buffer: FSM states,
// default seed, warm-up length, stuck-word repeat limit and level width.
package rng_pkg;

    typedef enum logic [1:0] {
        S_RESEED = 2'd0,
        S_WARMUP = 2'd1,
        S_FILL   = 2'd2
    } rng_state_e;

    localparam logic [31:0] RNG_SEED_DEFAULT = 32'hACE1_2468;
    localparam int          RNG_WARMUP       = 16;
    localparam int          RNG_REP_LIMIT    = 4;

    // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int rng_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous first-word-fall-through FIFO: o_head shows the oldest word
// whenever o_empty is low; flush empties it at the next edge.
module rng_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == (AW + 1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + (AW + 1)'(1);
            else if (!w_push && w_pop) r_level <= r_level - (AW + 1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/rng_prefetch.sv
// Seeds the LFSR stage, discards a warm-up run, then prefetches words into a
// FWFT FIFO for zero-wait register reads. `define RNG_STUCK_CHECK_EN adds a stuck-word health check.
module rng_prefetch
    import rng_pkg::*;
#(
    parameter int                  NUM_BITS     = 32,
    parameter int                  DEPTH        = 8,
    parameter int                  WARMUP       = RNG_WARMUP,
    parameter logic [NUM_BITS-1:0] SEED_DEFAULT = NUM_BITS'(RNG_SEED_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reg_dat_we,
    input  logic                   reg_dat_re,
    input  logic [NUM_BITS-1:0]    reg_dat_di,
    output logic [NUM_BITS-1:0]    reg_dat_do,
    output logic                   reg_dat_wait,
    output logic                   rng_enable,
    output logic                   rng_dat_we,
    output logic [NUM_BITS-1:0]    rng_dat_di,
    input  logic [NUM_BITS-1:0]    rng_dat_do,
    input  logic                   rng_dat_wait,
    output logic [$clog2(DEPTH):0] level,
    output logic                   health_fail,
    output rng_state_e             o_dbg_state
);

    localparam int LW = rng_level_w(DEPTH);
    localparam int CW = $clog2(WARMUP + 1);

    rng_state_e          r_state;
    rng_state_e          w_state_nxt;
    logic [NUM_BITS-1:0] r_seed;
    logic [CW-1:0]       r_warm_cnt;
    logic                w_warm_done;
    logic                w_full;
    logic                w_empty;
    logic                w_cand;
    logic                w_push;
    logic                w_pop;
    logic                w_health;
    logic [NUM_BITS-1:0] w_head;
    logic [LW-1:0]       w_level;

    // The seed-load cycle is the first discarded cycle, so WARMUP needs WARMUP-1 more.
    assign w_warm_done = !rng_dat_wait && (int'(r_warm_cnt) == WARMUP - 2);

    always_comb begin
        w_state_nxt = r_state;
        rng_enable  = 1'b0;
        rng_dat_we  = 1'b0;
        case (r_state)
            S_RESEED: begin
                rng_enable  = 1'b1;
                rng_dat_we  = 1'b1;
                w_state_nxt = (WARMUP == 1) ? S_FILL : S_WARMUP;
            end
            S_WARMUP: begin
                rng_enable = 1'b1;
                if (w_warm_done) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                rng_enable = !w_full && !w_health;
            end
            default: w_state_nxt = S_RESEED;
        endcase
        if (reg_dat_we) w_state_nxt = S_RESEED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RESEED;
            r_seed     <= SEED_DEFAULT;
            r_warm_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (reg_dat_we) r_seed <= reg_dat_di;
            if (r_state != S_WARMUP)  r_warm_cnt <= '0;
            else if (!rng_dat_wait)   r_warm_cnt <= r_warm_cnt + CW'(1);
        end
    end

    assign w_cand = (r_state == S_FILL) && rng_enable && !rng_dat_wait;

`ifdef RNG_STUCK_CHECK_EN
    localparam int RW = $clog2(RNG_REP_LIMIT + 1);

    logic [NUM_BITS-1:0] r_prev;
    logic                r_prev_vld;
    logic [RW-1:0]       r_rep_cnt;
    logic                r_health;
    logic                w_same;
    logic                w_stuck;

    assign w_same  = r_prev_vld && (rng_dat_do == r_prev);
    assign w_stuck = w_cand && w_same && (int'(r_rep_cnt) == RNG_REP_LIMIT - 1);
    assign w_push  = w_cand && !w_stuck;

    always_ff @(posedge clk) begin
        if (reset || reg_dat_we) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_rep_cnt  <= '0;
            r_health   <= 1'b0;
        end else if (w_cand) begin
            r_prev     <= rng_dat_do;
            r_prev_vld <= 1'b1;
            r_rep_cnt  <= w_same ? r_rep_cnt + RW'(1) : RW'(1);
            if (w_stuck) r_health <= 1'b1;
        end
    end

    assign w_health = r_health;
`else
    assign w_push   = w_cand;
    assign w_health = 1'b0;
`endif

    // Write wins over a concurrent read; once unhealthy an empty read returns 0 without stalling.
    assign w_pop = reg_dat_re && !reg_dat_we && !w_empty;

    always_comb begin
        reg_dat_wait = 1'b0;
        if (reg_dat_we)      reg_dat_wait = reg_dat_re;
        else if (reg_dat_re) reg_dat_wait = w_empty && !w_health;
    end

    rng_fifo #(
        .W     (NUM_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (reg_dat_we),
        .i_data  (rng_dat_do),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign reg_dat_do  = w_empty ? '0 : w_head;
    assign rng_dat_di  = r_seed;
    assign level       = w_level;
    assign health_fail = w_health;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rng_prefetch.sv
// Bench for rng_prefetch: the bench plays the LFSR stage and predicts every
// cycle from a queue-based model of warm-up, FIFO occupancy and the word stream.
module tb_rng_prefetch;

    localparam int          DEPTH     = 8;
    localparam int          WARMUP    = 16;
    localparam int          REP_LIMIT = 4;
    localparam logic [31:0] SEED0     = 32'hACE1_2468;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 reg_dat_we;
    logic                 reg_dat_re;
    logic [31:0]          reg_dat_di;
    logic [31:0]          reg_dat_do;
    logic                 reg_dat_wait;
    logic                 rng_enable;
    logic                 rng_dat_we;
    logic [31:0]          rng_dat_di;
    logic [31:0]          rng_dat_do;
    logic                 rng_dat_wait;
    logic [3:0]           level;
    logic                 health_fail;
    rng_pkg::rng_state_e  dbg_state;

    always #5 clk = ~clk;

    rng_prefetch dut (
        .clk          (clk),
        .reset        (reset),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait),
        .rng_enable   (rng_enable),
        .rng_dat_we   (rng_dat_we),
        .rng_dat_di   (rng_dat_di),
        .rng_dat_do   (rng_dat_do),
        .rng_dat_wait (rng_dat_wait),
        .level        (level),
        .health_fail  (health_fail),
        .o_dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: FIFO contents, expected next read word, warm-up countdown.
    logic [31:0] exp_q[$];
    logic [31:0] seed_m, exp_next, stage, prev_m;
    bit          load_pending, health_m, prev_vld_m, stream_chk, force_const;
    int          warm_left, rep_m;

    logic        drv_rst, drv_we, drv_re, drv_wait;
    logic [31:0] drv_di;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] lfsr_skip(input logic [31:0] s, input int n);
        logic [31:0] r = s;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    // Stream after a seed load: the load yields step(seed), then WARMUP-1 more words are dropped.
    task automatic model_seed(input logic [31:0] s);
        exp_q.delete();
        seed_m       = s;
        load_pending = 1'b1;
        warm_left    = 0;
        health_m     = 1'b0;
        rep_m        = 0;
        prev_vld_m   = 1'b0;
        exp_next     = lfsr_skip(s, WARMUP);
        stream_chk   = !force_const;
    endtask

    // Called at a negedge; applies inputs, checks, advances model, returns at next negedge.
    task automatic run_cycle();
        bit          filling, cand, push, pop;
        logic [31:0] word;
        reset        = drv_rst;
        reg_dat_we   = drv_we;
        reg_dat_re   = drv_re;
        reg_dat_di   = drv_di;
        rng_dat_wait = drv_wait;
        rng_dat_do   = force_const ? 32'hDEAD_BEEF : stage;
        #1;
        word = rng_dat_do;
        if (!drv_rst) begin
            check("rng_we", 32'(rng_dat_we), 32'(load_pending));
            check("rng_di", rng_dat_di, seed_m);
            check("rng_en", 32'(rng_enable),
                  32'(load_pending || warm_left > 0 || (exp_q.size() < DEPTH && !health_m)));
            check("level", 32'(level), 32'(exp_q.size()));
            check("rd_head", reg_dat_do, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
            check("rd_wait", 32'(reg_dat_wait),
                  32'(drv_we ? drv_re : (drv_re && exp_q.size() == 0 && !health_m)));
            check("health", 32'(health_fail), 32'(health_m));
        end
        if (rng_dat_we === 1'b1)                      stage = lfsr_step(rng_dat_di);
        else if (rng_enable === 1'b1 && !drv_wait)    stage = lfsr_step(stage);
        if (drv_rst) begin
            model_seed(SEED0);
        end else begin
            filling = !load_pending && warm_left == 0;
            pop     = drv_re && !drv_we && exp_q.size() > 0;
            cand    = filling && exp_q.size() < DEPTH && !health_m && !drv_wait;
            push    = cand;
`ifdef RNG_STUCK_CHECK_EN
            if (cand) begin
                rep_m      = (prev_vld_m && word == prev_m) ? rep_m + 1 : 1;
                prev_m     = word;
                prev_vld_m = 1'b1;
                if (rep_m >= REP_LIMIT) begin
                    health_m = 1'b1;
                    push     = 1'b0;
                end
            end
`endif
            if (pop) begin
                if (stream_chk) check("rd_stream", reg_dat_do, exp_next);
                exp_next = lfsr_step(exp_next);
                void'(exp_q.pop_front());
            end
            if (push) exp_q.push_back(word);
            if (load_pending) begin
                load_pending = 1'b0;
                warm_left    = WARMUP - 1;
            end else if (warm_left > 0 && !drv_wait) begin
                warm_left--;
            end
            if (drv_we) model_seed(drv_di);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        pat          = 8'b0100_1010;
        force_const  = 1'b0;
        stage        = 32'h0;
        drv_rst      = 1'b1;
        drv_we       = 1'b0;
        drv_re       = 1'b0;
        drv_wait     = 1'b0;
        drv_di       = 32'h0;
        reset        = 1'b1;
        reg_dat_we   = 1'b0;
        reg_dat_re   = 1'b0;
        reg_dat_di   = 32'h0;
        rng_dat_wait = 1'b0;
        rng_dat_do   = 32'h0;
        model_seed(SEED0);
        @(negedge clk);

        // Reset, then idle: seed load, 15 warm cycles, pushes in cycles 17..24.
        repeat (2) run_cycle();
        drv_rst = 1'b0;
        check("rst_state", 32'(dbg_state), 32'(rng_pkg::S_RESEED));
        check("rst_level", 32'(level), 32'h0);
        check("rst_do", reg_dat_do, 32'h0);
        check("rst_seed_we", 32'(rng_dat_we), 32'h1);
        check("rst_seed_di", rng_dat_di, SEED0);
        repeat (16) run_cycle();
        check("pre_push_lvl", 32'(level), 32'h0);
        run_cycle();
        check("first_push_lvl", 32'(level), 32'h1);
        repeat (7) run_cycle();
        check("full_lvl", 32'(level), 32'h8);
        check("full_en", 32'(rng_enable), 32'h0);

        // Eight back-to-back reads of a full FIFO; refill starts after the first pop.
        drv_re = 1'b1;
        run_cycle();
        check("refill_en", 32'(rng_enable), 32'h1);
        repeat (7) run_cycle();
        drv_re = 1'b0;
        repeat (2) run_cycle();

        // Write with read held, then keep reading an empty FIFO across warm-up.
        drv_we = 1'b1;
        drv_re = 1'b1;
        drv_di = $urandom | 32'h1;
        run_cycle();
        drv_we = 1'b0;
        check("flush_lvl", 32'(level), 32'h0);
        repeat (25) run_cycle();
        drv_re = 1'b0;

        // Seed write at level 5 with a concurrent read.
        for (int i = 0; i < 60 && exp_q.size() != 5; i++) run_cycle();
        check("lvl5_reach", 32'(exp_q.size()), 32'h5);
        check("lvl5_dut", 32'(level), 32'h5);
        drv_we = 1'b1;
        drv_re = 1'b1;
        drv_di = 32'h1234_5678;
        run_cycle();
        drv_we = 1'b0;
        drv_re = 1'b0;
        check("wr_lvl", 32'(level), 32'h0);
        check("wr_reseed_we", 32'(rng_dat_we), 32'h1);
        check("wr_reseed_di", rng_dat_di, 32'h1234_5678);
        repeat (30) run_cycle();
        drv_re = 1'b1;
        repeat (8) run_cycle();
        drv_re = 1'b0;

        // Three rng_dat_wait pulses in an 8-cycle fill window leave 5 words.
        drv_we = 1'b1;
        drv_di = $urandom | 32'h1;
        run_cycle();
        drv_we = 1'b0;
        for (int i = 0; i < 40 && (load_pending || warm_left != 0); i++) run_cycle();
        check("fill_reach", 32'(warm_left), 32'h0);
        for (int i = 0; i < 8; i++) begin
            drv_wait = pat[i];
            run_cycle();
        end
        drv_wait = 1'b0;
        check("stall_lvl", 32'(level), 32'h5);
        drv_re = 1'b1;
        repeat (10) run_cycle();
        drv_re = 1'b0;

        // Randomized traffic, including occasional reseeds and resets.
        for (int i = 0; i < 1500; i++) begin
            drv_rst  = ($urandom_range(0, 499) == 0);
            drv_we   = ($urandom_range(0, 99) < 2);
            drv_re   = $urandom_range(0, 1);
            drv_wait = ($urandom_range(0, 3) == 0);
            drv_di   = $urandom | 32'h1;
            run_cycle();
        end
        drv_rst  = 1'b0;
        drv_we   = 1'b0;
        drv_re   = 1'b0;
        drv_wait = 1'b0;
        run_cycle();

`ifdef RNG_STUCK_CHECK_EN
        // Stuck RNG output: three copies are buffered, the fourth trips the health flag.
        force_const = 1'b1;
        drv_we      = 1'b1;
        drv_di      = 32'h0BAD_F00D;
        run_cycle();
        drv_we = 1'b0;
        repeat (30) run_cycle();
        check("hf_set", 32'(health_fail), 32'h1);
        check("hf_en", 32'(rng_enable), 32'h0);
        check("hf_lvl", 32'(level), 32'h3);
        drv_re = 1'b1;
        repeat (3) run_cycle();
        check("hf_empty_wait", 32'(reg_dat_wait), 32'h0);
        check("hf_empty_do", reg_dat_do, 32'h0);
        drv_re      = 1'b0;
        force_const = 1'b0;
        drv_we      = 1'b1;
        drv_di      = 32'h5555_AAAA;
        run_cycle();
        drv_we = 1'b0;
        check("hf_clear", 32'(health_fail), 32'h0);
        repeat (30) run_cycle();
        drv_re = 1'b1;
        repeat (8) run_cycle();
        drv_re = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
